// File: rtl/mem32_bist_if.sv
// Control and memory-bus signals between mem32_bist and its 64x32 single-port memory.
// master = the BIST engine, slave = the controller/memory side.
interface mem32_bist_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_cnt;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    modport master (
        input  start, mem_rdata,
        output busy, done, pass, err_cnt, mem_we, mem_addr, mem_wdata, fail_addr, fail_data
    );

    modport slave (
        output start, mem_rdata,
        input  busy, done, pass, err_cnt, mem_we, mem_addr, mem_wdata, fail_addr, fail_data
    );
endinterface

// File: rtl/mem32_bist.sv
// March-style BIST for the 64x32 single-port memory: W0 up, R0/W1 up, R1 down, then report.
// Optional first-failure logging is enabled with `define MEM32_BIST_ERRLOG_EN.
module mem32_bist #(
    parameter int            AW      = 6,
    parameter int            DW      = 32,
    parameter logic [DW-1:0] PATTERN = 32'hA5A5_5A5A
) (
    input  logic         clk,
    input  logic         rst_n,
    mem32_bist_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] W0   = 3'd1;
    localparam logic [2:0] R0W1 = 3'd2;
    localparam logic [2:0] R1   = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [AW:0]   ERR_MAX  = '1;

    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_cnt;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic          cmp_en;
    logic [DW-1:0] exp_data;
    logic          mismatch;
    logic [AW:0]   err_next;

    // In R0W1, mem_we itself marks the sub-cycle: 0 = read/compare, 1 = write ~P.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cmp_en   = 1'b0;
        exp_data = PATTERN;
        if (state == R0W1 && !mem_we) begin
            cmp_en = 1'b1;
        end
        if (state == R1) begin
            cmp_en   = 1'b1;
            exp_data = ~PATTERN;
        end
        mismatch = cmp_en && (bus.mem_rdata != exp_data);
        err_next = (mismatch && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done    <= 1'b0;
            err_cnt <= err_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= W0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= PATTERN;
                    end
                end
                W0: begin
                    if (mem_addr == ADDR_MAX) begin
                        state    <= R0W1;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                R0W1: begin
                    if (!mem_we) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= ~PATTERN;
                    end else begin
                        mem_we <= 1'b0;
                        if (mem_addr == ADDR_MAX) begin
                            state <= R1;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                R1: begin
                    if (mem_addr == '0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Include the final R1 compare, which lands on this same edge.
                        pass  <= (err_next == '0);
                    end else begin
                        mem_addr <= mem_addr - 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.err_cnt   = err_cnt;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

`ifdef MEM32_BIST_ERRLOG_EN
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    // err_cnt is still zero on the edge that records the first mismatch of a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == IDLE && bus.start) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch && err_cnt == '0) begin
            fail_addr <= mem_addr;
            fail_data <= bus.mem_rdata;
        end
    end

    assign bus.fail_addr = fail_addr;
    assign bus.fail_data = fail_data;
`else
    assign bus.fail_addr = '0;
    assign bus.fail_data = '0;
`endif
endmodule

// File: tb/tb_mem32_bist.sv
// Self-checking bench for mem32_bist: behavioural 64x32 memory with injectable read faults
// and an abstract March model that predicts err_cnt, pass and the first failure.
module tb_mem32_bist;
    localparam int          AW = 6;
    localparam int          DW = 32;
    localparam logic [31:0] P  = 32'hA5A5_5A5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mem32_bist_if #(.AW(AW), .DW(DW)) bus ();

    mem32_bist #(.AW(AW), .DW(DW), .PATTERN(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Fault modes: 0 none, 1 stuck bit (fa/fb/fv) on reads, 2 every read returns 0.
    int          fmode = 0;
    logic [5:0]  fa    = '0;
    int          fb    = 0;
    logic        fv    = 1'b0;
    logic [31:0] mem [64];

    function automatic logic [31:0] read_fault(input logic [5:0] a, input logic [31:0] d,
                                                input int mode, input logic [5:0] faddr,
                                                input int fbit, input logic fval);
        logic [31:0] r;
        r = d;
        if (mode == 1 && a == faddr) r[fbit] = fval;
        else if (mode == 2)          r = '0;
        return r;
    endfunction

    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = read_fault(bus.mem_addr, mem[bus.mem_addr], fmode, fa, fb, fv);

    int          exp_err;
    logic        exp_pass;
    logic [5:0]  exp_faddr;
    logic [31:0] exp_fdata;

    // March algorithm at word level: write P everywhere, read P / write ~P upward, read ~P downward.
    task automatic build_expected();
        logic [31:0] m [64];
        logic [31:0] r;
        int errs;
        bit seen;
        errs = 0; seen = 0; exp_faddr = '0; exp_fdata = '0;
        for (int a = 0; a < 64; a++) m[a] = P;
        for (int a = 0; a < 64; a++) begin
            r = read_fault(6'(a), m[a], fmode, fa, fb, fv);
            if (r !== P) begin
                errs++;
                if (!seen) begin seen = 1; exp_faddr = 6'(a); exp_fdata = r; end
            end
            m[a] = ~P;
        end
        for (int a = 63; a >= 0; a--) begin
            r = read_fault(6'(a), m[a], fmode, fa, fb, fv);
            if (r !== ~P) begin
                errs++;
                if (!seen) begin seen = 1; exp_faddr = 6'(a); exp_fdata = r; end
            end
        end
        exp_err  = (errs > 127) ? 127 : errs;
        exp_pass = (errs == 0);
`ifndef MEM32_BIST_ERRLOG_EN
        exp_faddr = '0;
        exp_fdata = '0;
`endif
    endtask

    task automatic run_and_check(input string name, input int restart_at);
        int          done_cyc, pulses, busy_cyc, we_bad, bad_words;
        int          err_d;
        logic        pass_d;
        logic [5:0]  fa_d;
        logic [31:0] fd_d;
        done_cyc = -1; pulses = 0; busy_cyc = 0; we_bad = 0; bad_words = 0;
        err_d = -1; pass_d = 1'bx; fa_d = 'x; fd_d = 'x;
        build_expected();
        repeat ($urandom_range(0, 4)) @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 262; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == restart_at);
            if (bus.busy) busy_cyc++;
            if (!bus.busy && bus.mem_we) we_bad++;
            if (bus.done) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; err_d = int'(bus.err_cnt); pass_d = bus.pass;
                    fa_d = bus.fail_addr; fd_d = bus.fail_data;
                end
            end
        end
        for (int a = 0; a < 64; a++) if (mem[a] !== ~P) bad_words++;

        tests_run++;
        if (done_cyc !== 257) begin
            tests_failed++; $display("FAIL %s done_cycle: got %0d expected 257", name, done_cyc);
        end
        tests_run++;
        if (pulses !== 1) begin
            tests_failed++; $display("FAIL %s done_pulses: got %0d expected 1", name, pulses);
        end
        tests_run++;
        if (busy_cyc !== 256) begin
            tests_failed++; $display("FAIL %s busy_cycles: got %0d expected 256", name, busy_cyc);
        end
        tests_run++;
        if (we_bad !== 0) begin
            tests_failed++; $display("FAIL %s we_while_idle: got %0d expected 0", name, we_bad);
        end
        tests_run++;
        if (err_d !== exp_err || pass_d !== exp_pass) begin
            tests_failed++;
            $display("FAIL %s result: err_cnt=%0d pass=%b expected err_cnt=%0d pass=%b",
                     name, err_d, pass_d, exp_err, exp_pass);
        end
        tests_run++;
        if (fa_d !== exp_faddr || fd_d !== exp_fdata) begin
            tests_failed++;
            $display("FAIL %s errlog: addr=%0d data=%h expected addr=%0d data=%h",
                     name, fa_d, fd_d, exp_faddr, exp_fdata);
        end
        tests_run++;
        if (bus.pass !== exp_pass || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s hold: pass=%b busy=%b expected pass=%b busy=0",
                     name, bus.pass, bus.busy, exp_pass);
        end
        tests_run++;
        if (bad_words !== 0) begin
            tests_failed++; $display("FAIL %s final_memory: %0d words differ from %h", name, bad_words, ~P);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.fail_addr, bus.fail_data} !== '0) begin
            tests_failed++; $display("FAIL reset_held: outputs not at reset values (busy=%b we=%b addr=%0d)",
                                     bus.busy, bus.mem_we, bus.mem_addr);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.mem_we, bus.mem_addr,
                 bus.mem_wdata, bus.fail_addr, bus.fail_data} !== '0) begin
                tests_failed++; $display("FAIL idle_cycle_%0d: busy=%b done=%b we=%b err=%0d expected all 0",
                                         i, bus.busy, bus.done, bus.mem_we, bus.err_cnt);
            end
        end
    endtask

    task automatic test_fault_free();
        fmode = 0;
        run_and_check("fault_free", 0);
    endtask

    task automatic test_stuck_fault();
        fmode = 1; fa = 6'd10; fb = 0; fv = 1'b1;
        run_and_check("stuck_w10_b0", 0);
        for (int i = 0; i < 3; i++) begin
            fa = 6'($urandom_range(0, 63));
            fb = $urandom_range(0, 31);
            fv = 1'($urandom_range(0, 1));
            run_and_check($sformatf("stuck_rand%0d", i), 0);
        end
        fmode = 0;
    endtask

    task automatic test_saturation();
        fmode = 2;
        run_and_check("read_zero_sat", 0);
        fmode = 0;
    endtask

    task automatic test_start_while_busy();
        fmode = 0;
        run_and_check("start_busy_c50", 50);
        run_and_check("start_busy_rand", $urandom_range(2, 255));
        // start coincident with done must also be ignored.
        run_and_check("start_at_done", 257);
    endtask

    task automatic test_reset_mid_run();
        fmode = 0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.fail_addr, bus.fail_data} !== '0) begin
            tests_failed++; $display("FAIL mid_run_reset: busy=%b we=%b addr=%0d wdata=%h expected all 0",
                                     bus.busy, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_and_check("clean_after_reset", 0);
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck_fault();
        test_saturation();
        test_start_while_busy();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
